// File: rtl/wfm_pkg.sv
// Shared definitions for the waveform memory sequencer: the USB command codes,
// the controller state encoding (also shown on the status LEDs) and the
// threshold-step decode.
package wfm_pkg;

  localparam logic [7:0] CMD_CLR    = 8'd1;
  localparam logic [7:0] CMD_ACLR   = 8'd2;
  localparam logic [7:0] CMD_PAT    = 8'd3;
  localparam logic [7:0] CMD_IDLE   = 8'd4;
  localparam logic [7:0] CMD_XFER   = 8'd5;
  localparam logic [7:0] CMD_INIT   = 8'd6;
  localparam logic [7:0] CMD_NORMAL = 8'd7;
  localparam logic [7:0] CMD_LEN    = 8'd8;
  localparam logic [7:0] CMD_THU32  = 8'd16;
  localparam logic [7:0] CMD_THD32  = 8'd17;
  localparam logic [7:0] CMD_THU4   = 8'd18;
  localparam logic [7:0] CMD_THD4   = 8'd19;

  // The numeric value of each state is what the LEDs display.
  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_ARM   = 4'd1,
    ST_CAPT  = 4'd2,
    ST_CLR   = 4'd3,
    ST_PAT   = 4'd4,
    ST_XRD   = 4'd5,
    ST_XWT   = 4'd6,
    ST_XPUSH = 4'd7
  } state_t;

  typedef enum logic [2:0] {
    THR_NOP,
    THR_UP32,
    THR_DN32,
    THR_UP4,
    THR_DN4
  } thr_op_t;

  // Maps a command code onto a threshold step; anything else is a no-op.
  function automatic thr_op_t thr_decode(input logic [7:0] code);
    thr_op_t op;
    case (code)
      CMD_THU32: op = THR_UP32;
      CMD_THD32: op = THR_DN32;
      CMD_THU4:  op = THR_UP4;
      CMD_THD4:  op = THR_DN4;
      default:   op = THR_NOP;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/wfm_seq_ctrl_if.sv
// Command, sample, RAM-port, TX-FIFO and status signals of the waveform
// sequencer. The master side is the sequencer; the slave side is the
// surrounding board logic (USB core, ADC path, RAM, FIFO).
interface wfm_seq_ctrl_if #(
  parameter int ADDR_W = 10,
  parameter int DAT_W  = 10
);

  logic [7:0]        CMD;
  logic              CMD_STB;
  logic [DAT_W-1:0]  ADC_D;
  logic              ADC_VLD;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic              MEM_WE;
  logic [DAT_W-1:0]  MEM_WD;
  logic [DAT_W-1:0]  MEM_RD;
  logic              TX_FULL;
  logic              TX_WR;
  logic [15:0]       TX_D;
  logic [DAT_W-1:0]  THR;
  logic              BUSY;
  logic              FULL;
  logic [3:0]        LX;

  modport master (
    input  CMD, CMD_STB, ADC_D, ADC_VLD, MEM_RD, TX_FULL,
    output MEM_ADDR, MEM_WE, MEM_WD, TX_WR, TX_D, THR, BUSY, FULL, LX
  );

  modport slave (
    output CMD, CMD_STB, ADC_D, ADC_VLD, MEM_RD, TX_FULL,
    input  MEM_ADDR, MEM_WE, MEM_WD, TX_WR, TX_D, THR, BUSY, FULL, LX
  );

endinterface

// File: rtl/wfm_thr_adj.sv
// Trigger threshold register. Steps up or down by 32 or 4 on command and
// clamps at 0 and full scale instead of wrapping; reloads the power-up value
// on reset or on the init command.
module wfm_thr_adj
  import wfm_pkg::*;
#(
  parameter int DAT_W    = 10,
  parameter int THR_INIT = 512
) (
  input  logic             CLK,
  input  logic             RESD,
  input  logic             init,
  input  thr_op_t          op,
  output logic [DAT_W-1:0] THR
);

  localparam logic [DAT_W:0]   THR_MAX = {1'b0, {DAT_W{1'b1}}};
  localparam logic [DAT_W-1:0] THR_RST = DAT_W'(THR_INIT);

  // One extra bit of headroom lets the up-step detect overflow before clamping.
  function automatic logic [DAT_W-1:0] sat_adj(input logic [DAT_W-1:0] cur,
                                               input thr_op_t op_i);
    logic [DAT_W:0] wide;
    logic [DAT_W:0] step;
    step = (op_i == THR_UP32 || op_i == THR_DN32) ? (DAT_W+1)'(32) : (DAT_W+1)'(4);
    wide = {1'b0, cur};
    case (op_i)
      THR_UP32, THR_UP4: begin
        wide = wide + step;
        if (wide > THR_MAX) wide = THR_MAX;
      end
      THR_DN32, THR_DN4: begin
        wide = (wide < step) ? '0 : wide - step;
      end
      default: ;
    endcase
    return wide[DAT_W-1:0];
  endfunction

  // Init wins over a step; a new value is used by the next trigger compare.
  always_ff @(posedge CLK) begin
    if (RESD || init) begin
      THR <= THR_RST;
    end else if (op != THR_NOP) begin
      THR <= sat_adj(THR, op);
    end
  end

endmodule

// File: rtl/wfm_seq_ctrl.sv
// Waveform memory sequencer. Decodes USB commands and drives the waveform RAM:
// triggered capture of ADC samples, clear, address-pattern fill, and read-out
// of the RAM to the USB TX FIFO with back-pressure. Abort/init commands are
// honoured in every state; mode commands only while idle.
module wfm_seq_ctrl
  import wfm_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int DAT_W     = 10,
  parameter int THR_INIT  = 512,
  parameter int LEN_SHORT = 128
) (
  input  logic          CLK,
  input  logic          RESD,
  wfm_seq_ctrl_if.master bus
);

  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
  localparam logic [ADDR_W:0]   LEN_FULL  = (ADDR_W+1)'(2**ADDR_W);
  localparam logic [ADDR_W:0]   LEN_SHRT  = (ADDR_W+1)'(LEN_SHORT);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [ADDR_W:0]   cnt_inc;
  logic [ADDR_W:0]   len_q, len_d;
  logic              full_q, full_d;
  logic [DAT_W-1:0]  tx_d_p1, tx_d_d;
  logic              mem_we;
  logic [DAT_W-1:0]  mem_wd;
  logic              tx_wr;
  logic              cmd_init;
  logic              cmd_abort;
  thr_op_t           thr_op;
  logic [DAT_W-1:0]  thr;

  assign cmd_init  = bus.CMD_STB && (bus.CMD == CMD_INIT);
  assign cmd_abort = bus.CMD_STB && (bus.CMD == CMD_IDLE);
  assign thr_op    = bus.CMD_STB ? thr_decode(bus.CMD) : THR_NOP;
  assign cnt_inc   = cnt_q + 1'b1;

  wfm_thr_adj #(
    .DAT_W    (DAT_W),
    .THR_INIT (THR_INIT)
  ) u_thr_adj (
    .CLK  (CLK),
    .RESD (RESD),
    .init (cmd_init),
    .op   (thr_op),
    .THR  (thr)
  );

  // Next-state and RAM/FIFO strobes; abort and init pre-empt any state action.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    full_d  = full_q;
    tx_d_d  = tx_d_p1;
    mem_we  = 1'b0;
    mem_wd  = '0;
    tx_wr   = 1'b0;

    if (cmd_init || cmd_abort) begin
      state_d = ST_IDLE;
      addr_d  = '0;
      if (cmd_init) begin
        len_d  = LEN_FULL;
        full_d = 1'b0;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.CMD_STB) begin
            case (bus.CMD)
              CMD_NORMAL: begin
                state_d = ST_ARM;
                full_d  = 1'b0;
                addr_d  = '0;
              end
              CMD_CLR: begin
                state_d = ST_CLR;
                addr_d  = '0;
              end
              CMD_PAT: begin
                state_d = ST_PAT;
                addr_d  = '0;
              end
              CMD_XFER: begin
                state_d = ST_XRD;
                addr_d  = '0;
                cnt_d   = '0;
              end
              CMD_ACLR: addr_d = '0;
              CMD_LEN:  len_d  = LEN_SHRT;
              default: ;
            endcase
          end
        end

        // The sample that fires the trigger is itself the first stored word.
        ST_ARM: begin
          if (bus.ADC_VLD && (bus.ADC_D > thr)) begin
            mem_we  = 1'b1;
            mem_wd  = bus.ADC_D;
            addr_d  = addr_q + 1'b1;
            state_d = ST_CAPT;
          end
        end

        ST_CAPT: begin
          if (bus.ADC_VLD) begin
            mem_we = 1'b1;
            mem_wd = bus.ADC_D;
            if (addr_q == ADDR_LAST) begin
              full_d  = 1'b1;
              addr_d  = '0;
              state_d = ST_IDLE;
            end else begin
              addr_d = addr_q + 1'b1;
            end
          end
        end

        ST_CLR, ST_PAT: begin
          mem_we = 1'b1;
          mem_wd = (state_q == ST_PAT) ? DAT_W'(addr_q) : '0;
          if (addr_q == ADDR_LAST) begin
            addr_d  = '0;
            state_d = ST_IDLE;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end

        // RAM sees the address this cycle and returns data on the next.
        ST_XRD: state_d = ST_XWT;

        ST_XWT: begin
          tx_d_d  = bus.MEM_RD;
          state_d = ST_XPUSH;
        end

        // Hold the word until the FIFO has room; never write into a full FIFO.
        ST_XPUSH: begin
          if (!bus.TX_FULL) begin
            tx_wr = 1'b1;
            cnt_d = cnt_inc;
            if (cnt_inc == len_q) begin
              addr_d  = '0;
              state_d = ST_IDLE;
            end else begin
              addr_d  = addr_q + 1'b1;
              state_d = ST_XRD;
            end
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end

    // Nothing leaves the block toward RAM or FIFO while reset is held.
    if (RESD) begin
      mem_we = 1'b0;
      mem_wd = '0;
      tx_wr  = 1'b0;
    end
  end

  // Controller and output registers; everything returns to its reset value.
  always_ff @(posedge CLK) begin
    if (RESD) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      len_q   <= LEN_FULL;
      full_q  <= 1'b0;
      tx_d_p1 <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      full_q  <= full_d;
      tx_d_p1 <= tx_d_d;
    end
  end

  assign bus.MEM_ADDR = addr_q;
  assign bus.MEM_WE   = mem_we;
  assign bus.MEM_WD   = mem_wd;
  assign bus.TX_WR    = tx_wr;
  assign bus.TX_D     = 16'(tx_d_p1);
  assign bus.THR      = thr;
  assign bus.BUSY     = (state_q != ST_IDLE);
  assign bus.FULL     = full_q;
  assign bus.LX       = state_q;

endmodule
